pwm_gen: RTL

//  Multi-channel PWM / pulse generator driving GPIO pins; output-side counterpart of the edge-capture timer.

---
 rtl/pwm_gen_if.sv | 25 ++
 rtl/pwm_gen.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pwm_gen_if.sv
// Register-file side of the PWM block: per-channel configuration and load strobes in,
// GPIO waveform and per-channel status out.
interface pwm_gen_if #(
    parameter int CORE_WIDTH          = 4,
    parameter int TIMER_COUNTER_WIDTH = 16
);
    logic [CORE_WIDTH-1:0]                     pwm_enable;
    logic [2*CORE_WIDTH-1:0]                   pwm_conf;
    logic [CORE_WIDTH*TIMER_COUNTER_WIDTH-1:0] pwm_period;
    logic [CORE_WIDTH*TIMER_COUNTER_WIDTH-1:0] pwm_duty;
    logic [CORE_WIDTH-1:0]                     pwm_load;
    logic [CORE_WIDTH-1:0]                     pwm_out;
    logic [CORE_WIDTH-1:0]                     pwm_period_done;
    logic [CORE_WIDTH-1:0]                     pwm_busy;

    modport master (
        output pwm_enable, pwm_conf, pwm_period, pwm_duty, pwm_load,
        input  pwm_out, pwm_period_done, pwm_busy
    );

    modport slave (
        input  pwm_enable, pwm_conf, pwm_period, pwm_duty, pwm_load,
        output pwm_out, pwm_period_done, pwm_busy
    );
endinterface

// File: rtl/pwm_gen.sv
// Multi-channel PWM / one-shot pulse generator. Every channel counts shared prescaler ticks
// and drives a registered period/duty waveform; period/duty are double-buffered per channel.
module pwm_gen #(
    parameter int CORE_WIDTH          = 4,
    parameter int TIMER_COUNTER_WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     ps_clk,
    pwm_gen_if.slave bus
);
    localparam int W = TIMER_COUNTER_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    logic ps_s1;
    logic ps_s2;
    logic tick;

    // NOTE: the reset is synchronous, so it sits inside the clocked block and needs no sensitivity entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_s1 <= 1'b0;
            ps_s2 <= 1'b0;
        end else begin
            ps_s1 <= ps_clk;
            ps_s2 <= ps_s1;
        end
    end

    assign tick = ps_s1 & ~ps_s2;

    for (genvar c = 0; c < CORE_WIDTH; c++) begin : g_ch
        state_t       state, state_n;
        logic [W-1:0] cnt, cnt_n;
        logic [W-1:0] act_per, act_per_n;
        logic [W-1:0] act_duty, act_duty_n;
        logic [W-1:0] pend_per, pend_per_n;
        logic [W-1:0] pend_duty, pend_duty_n;
        logic         pend_valid, pend_valid_n;
        logic         out_q, out_n;
        logic         done_q, done_n;
        logic         polarity;
        logic         one_shot;
        logic         wrap;

        assign polarity = bus.pwm_conf[c];
        assign one_shot = bus.pwm_conf[c+CORE_WIDTH];
        assign wrap     = tick && (cnt == act_per - W'(1));

        // NOTE: all state is written with <= so every register samples the same pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                state      <= IDLE;
                cnt        <= '0;
                act_per    <= '0;
                act_duty   <= '0;
                pend_per   <= '0;
                pend_duty  <= '0;
                pend_valid <= 1'b0;
                out_q      <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                state      <= state_n;
                cnt        <= cnt_n;
                act_per    <= act_per_n;
                act_duty   <= act_duty_n;
                pend_per   <= pend_per_n;
                pend_duty  <= pend_duty_n;
                pend_valid <= pend_valid_n;
                out_q      <= out_n;
                done_q     <= done_n;
            end
        end

        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        always_comb begin
            state_n      = state;
            cnt_n        = cnt;
            act_per_n    = act_per;
            act_duty_n   = act_duty;
            pend_per_n   = pend_per;
            pend_duty_n  = pend_duty;
            pend_valid_n = pend_valid;
            done_n       = 1'b0;

            // A load lands in the pending regs first, so a start or wrap on the same clk already sees it.
            if (bus.pwm_load[c]) begin
                pend_per_n   = bus.pwm_period[W*c +: W];
                pend_duty_n  = bus.pwm_duty[W*c +: W];
                pend_valid_n = 1'b1;
            end

            if (!bus.pwm_enable[c]) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (pend_per_n != '0) begin
                            state_n      = RUN;
                            act_per_n    = pend_per_n;
                            act_duty_n   = pend_duty_n;
                            pend_valid_n = 1'b0;
                            cnt_n        = '0;
                        end
                    end
                    RUN: begin
                        if (wrap) begin
                            cnt_n  = '0;
                            done_n = 1'b1;
                            if (pend_valid_n) begin
                                // A zero period is never made active; it is dropped here instead.
                                if (pend_per_n != '0) begin
                                    act_per_n  = pend_per_n;
                                    act_duty_n = pend_duty_n;
                                end
                                pend_valid_n = 1'b0;
                            end
                            if (one_shot) begin
                                state_n = HOLD;
                            end
                        end else if (tick) begin
                            cnt_n = cnt + W'(1);
                        end
                    end
                    HOLD: begin
                        state_n = HOLD;
                    end
                    default: begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                endcase
            end

            out_n = ((state_n == RUN) && (cnt_n < act_duty_n)) ^ polarity;
        end

        assign bus.pwm_out[c]         = out_q;
        assign bus.pwm_period_done[c] = done_q;
        assign bus.pwm_busy[c]        = (state == RUN);
    end
endmodule
